ra_cfg_load_ddr: RTL and testbench

Serial configuration loader for the DDR test array shard. It deserializes framed bits from a one-wire test pin pair (`sdi`/`sdi_vld`) and issues single-cycle `cfg_wr`/`cfg_dat` writes to `ra_cfg_ddr`, so it is the transmitter end of that config-write interface. It sits beside `ra_bist_ddr` in the shard top and runs on the 1x array clock, `clk`, the same clock as `ra_cfg_ddr`.

---
 rtl/ra_pkg.sv | 23 ++
 rtl/ra_cfg_load_ddr.sv | 142 ++++++++++++++
 tb/tb_ra_cfg_load_ddr.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ra_pkg.sv
// Shared definitions for the DDR test array shard.
// The config word width comes from LCBDDR_CONFIGWIDTH. If the including build
// has not already defined it, it falls back to 16.
`ifndef LCBDDR_CONFIGWIDTH
`define LCBDDR_CONFIGWIDTH 16
`endif

package ra_pkg;

  // Serial config loader frame states. PAR is only reachable when parity is built in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    STOP  = 2'd3
  } ra_cfg_load_state_t;

  localparam logic RA_CFG_START_BIT = 1'b1;
  localparam logic RA_CFG_STOP_BIT  = 1'b0;

  localparam int RA_CFG_WIDTH_DEFAULT = `LCBDDR_CONFIGWIDTH;

endpackage

// File: rtl/ra_cfg_load_ddr.sv
// Serial configuration loader for the DDR test array shard.
// Deserializes frames from sdi/sdi_vld and issues single-cycle cfg_wr/cfg_dat
// writes to ra_cfg_ddr. The frame is: start bit 1, CFG_WIDTH data bits with the
// first bit landing in cfg_dat[0], an optional parity bit, and stop bit 0.
// Optional feature macro: RA_CFG_PARITY_EN adds the parity bit and PAR state.
`ifndef LCBDDR_CONFIGWIDTH
`define LCBDDR_CONFIGWIDTH 16
`endif

module ra_cfg_load_ddr
  import ra_pkg::*;
#(
  parameter int CFG_WIDTH = RA_CFG_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sdi,
  input  logic                 sdi_vld,
  input  logic                 err_clr,
  output logic                 cfg_wr,
  output logic [0:CFG_WIDTH-1] cfg_dat,
  output logic                 busy,
  output logic                 err
);

  localparam int CNT_W = $clog2(CFG_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_WIDTH - 1);

  ra_cfg_load_state_t   state;
  ra_cfg_load_state_t   state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [0:CFG_WIDTH-1] shadow;
  logic                 last_bit;
  logic                 stop_good;
  logic                 err_set;

`ifdef RA_CFG_PARITY_EN
  logic perr;
  assign stop_good = (sdi == RA_CFG_STOP_BIT) && !perr;
`else
  assign stop_good = (sdi == RA_CFG_STOP_BIT);
`endif

  assign last_bit = (cnt == CNT_LAST);
  assign err_set  = (state == STOP) && sdi_vld && !stop_good;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of the order of the always blocks.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode. The FSM holds whenever sdi_vld is low.
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_nxt unassigned and
    // no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sdi_vld && (sdi == RA_CFG_START_BIT)) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (sdi_vld && last_bit) begin
`ifdef RA_CFG_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = STOP;
`endif
        end
      end
      PAR: begin
        if (sdi_vld) state_nxt = STOP;
      end
      STOP: begin
        if (sdi_vld) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode. busy covers SHIFT through the stop-bit cycle.
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: shift register, bit counter, write strobe and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: shadow is an ordinary register, not a memory. It is cleared here so
      // that the reset state is fully defined.
      cnt     <= '0;
      shadow  <= '0;
      cfg_dat <= '0;
      cfg_wr  <= 1'b0;
      err     <= 1'b0;
`ifdef RA_CFG_PARITY_EN
      perr    <= 1'b0;
`endif
    end else begin
      cfg_wr <= 1'b0;

      // When a set and a clear land in the same cycle, the set wins.
      if (err_set) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (sdi_vld && (sdi == RA_CFG_START_BIT)) cnt <= '0;
        end
        SHIFT: begin
          if (sdi_vld) begin
            shadow[cnt] <= sdi;
            cnt         <= cnt + CNT_W'(1);
          end
        end
`ifdef RA_CFG_PARITY_EN
        PAR: begin
          // Even parity: the parity bit equals the XOR of the data bits.
          if (sdi_vld) perr <= (sdi != ^shadow);
        end
`endif
        STOP: begin
          // cfg_dat changes only on a clean frame. A bad frame leaves it untouched.
          if (sdi_vld && stop_good) begin
            cfg_dat <= shadow;
            cfg_wr  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ra_cfg_load_ddr.sv
// Self-checking bench for ra_cfg_load_ddr.
// The reference model works at the frame level. For each frame it decides
// good or bad from the stop and parity rules, then tracks the expected write
// count, the last written word and the sticky error.
// Honours RA_CFG_PARITY_EN in the same way as the design.
module tb_ra_cfg_load_ddr;

  localparam int W = 16;
`ifdef RA_CFG_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         sdi;
  logic         sdi_vld;
  logic         err_clr;
  logic         cfg_wr;
  logic [0:W-1] cfg_dat;
  logic         busy;
  logic         err;

  always #5 clk = ~clk;

  ra_cfg_load_ddr #(.CFG_WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .sdi     (sdi),
    .sdi_vld (sdi_vld),
    .err_clr (err_clr),
    .cfg_wr  (cfg_wr),
    .cfg_dat (cfg_dat),
    .busy    (busy),
    .err     (err)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  int           wr_seen  = 0;
  int           exp_wr   = 0;
  logic [0:W-1] exp_dat  = '0;
  bit           exp_err  = 1'b0;
  int           busy_bad = 0;
  bit           clr_on_stop = 1'b0;
  bit           start_saw_wr = 1'b0;

  // Count write pulses sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (cfg_wr === 1'b1) wr_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sdi_vld = 1'b0;
      sdi     = 1'($urandom);
      err_clr = 1'b0;
    end
  endtask

  // gap >= 0: a fixed number of invalid cycles before each bit after the start.
  // gap < 0: a random 0..3 invalid cycles before each such bit.
  task automatic send_frame(input logic [0:W-1] d, input bit par, input bit stopb, input int gap);
    bit bits[$];
    bit good;
    bits.push_back(1'b1);
    for (int i = 0; i < W; i++) bits.push_back(d[i]);
    if (PAR_EN) bits.push_back(par);
    bits.push_back(stopb);
    for (int k = 0; k < bits.size(); k++) begin
      if (k > 0) begin
        int g;
        g = (gap >= 0) ? gap : int'($urandom_range(3, 0));
        repeat (g) begin
          @(negedge clk);
          if (busy !== 1'b1) busy_bad++;
          sdi_vld = 1'b0;
          sdi     = 1'($urandom);
          err_clr = 1'b0;
        end
      end
      @(negedge clk);
      if (k == 0) start_saw_wr = (cfg_wr === 1'b1);
      if (k > 0 && busy !== 1'b1) busy_bad++;
      sdi_vld = 1'b1;
      sdi     = bits[k];
      err_clr = (k == bits.size() - 1) && clr_on_stop;
    end
    good = (stopb == 1'b0) && (!PAR_EN || (par == ^d));
    if (good) begin
      exp_dat = d;
      exp_wr++;
      if (clr_on_stop) exp_err = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    idle(3);
    check({tag, "_wrcnt"}, 32'(wr_seen), 32'(exp_wr));
    check({tag, "_dat"}, 32'(cfg_dat), 32'(exp_dat));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [0:W-1] d;
    bit           p;
    bit           s;

    reset   = 1'b1;
    sdi     = 1'b0;
    sdi_vld = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr", 32'(cfg_wr), 32'd0);
    check("rst_dat", 32'(cfg_dat), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    idle(2);

    // Continuous frame: the pulse appears the cycle after the stop bit and lasts one cycle.
    send_frame(16'hA5C3, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("a5c3_pulse", 32'(cfg_wr), 32'd1);
    check("a5c3_pdat", 32'(cfg_dat), 32'hA5C3);
    sdi_vld = 1'b0;
    @(negedge clk);
    check("a5c3_pulse_end", 32'(cfg_wr), 32'd0);
    check_state("a5c3");

    // Same frame with sdi_vld low every other cycle.
    busy_bad = 0;
    send_frame(16'hA5C3, 1'b0, 1'b0, 1);
    check_state("a5c3_gap");
    check("a5c3_gap_busy", 32'(busy_bad), 32'd0);

    // A bad stop bit sets err and leaves cfg_dat alone. err_clr then clears err.
    send_frame(16'h1234, 1'b0, 1'b1, 0);
    check_state("bad_stop");
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    check("err_clr", 32'(err), 32'd0);

    // Parity mismatch when parity is built in; plain short frame otherwise.
    send_frame(16'h0001, 1'b0, 1'b0, 0);
    check_state("par_0001");

    // A set and a clear in the same cycle leave err set.
    clr_on_stop = 1'b1;
    send_frame(16'h5555, 1'b0, 1'b1, 0);
    clr_on_stop = 1'b0;
    check_state("set_wins");

    // Reset after 7 data bits discards the partial frame.
    @(negedge clk);
    sdi_vld = 1'b1;
    sdi     = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      sdi = 1'($urandom);
    end
    @(negedge clk);
    reset   = 1'b1;
    sdi_vld = 1'b0;
    @(negedge clk);
    reset   = 1'b0;
    exp_dat = '0;
    exp_err = 1'b0;
    check("midrst_dat", 32'(cfg_dat), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    send_frame(16'h00FF, 1'b0, 1'b0, 0);
    check_state("midrst_00ff");

    // Back-to-back: the second start bit is driven during the cfg_wr cycle.
    send_frame(16'h3C3C, 1'b0, 1'b0, 0);
    send_frame(16'hBEEF, 1'b0, 1'b0, 0);
    check("b2b_start_in_wr", 32'(start_saw_wr), 32'd1);
    check_state("b2b");

    // Random frames with random gaps and occasional bad stop or parity bits.
    for (int n = 0; n < 24; n++) begin
      d = W'($urandom);
      p = (^d) ^ ($urandom_range(4, 0) == 0);
      s = ($urandom_range(5, 0) == 0);
      busy_bad = 0;
      send_frame(d, p, s, -1);
      check_state($sformatf("rnd%0d", n));
      check($sformatf("rnd%0d_busy", n), 32'(busy_bad), 32'd0);
      if ($urandom_range(2, 0) == 0) begin
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = 1'b0;
      end
    end
    idle(2);
    check("final_err", 32'(err), 32'(exp_err));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
